// File: rtl/icache_prefetch_ctrl_if.sv
// Bus types and the ICache <-> memory request/return interface.
// master: controller side (drives command/addr); slave: memory side.
package icache_prefetch_pkg;
    localparam int XLEN       = 32;
    localparam int MEM_ADDR_W = 16;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;
endpackage

interface icache_prefetch_ctrl_if #(
    parameter int TAG_W = 4
);
    import icache_prefetch_pkg::*;

    BUS_COMMAND       Ictrl2Imem_command;
    logic [XLEN-1:0]  Ictrl2Imem_addr;
    logic [TAG_W-1:0] Imem2Ictrl_response;
    logic [TAG_W-1:0] Imem2Ictrl_tag;
    logic [63:0]      Imem2Ictrl_data;
    logic             reject_I_req;

    modport master (
        output Ictrl2Imem_command,
        output Ictrl2Imem_addr,
        input  Imem2Ictrl_response,
        input  Imem2Ictrl_tag,
        input  Imem2Ictrl_data,
        input  reject_I_req
    );

    modport slave (
        input  Ictrl2Imem_command,
        input  Ictrl2Imem_addr,
        output Imem2Ictrl_response,
        output Imem2Ictrl_tag,
        output Imem2Ictrl_data,
        output reject_I_req
    );
endinterface

// File: rtl/icache_prefetch_ctrl.sv
// ICache miss/prefetch controller: MSHR tracking, next-line prefetch, fills.
// Ports: clock/reset, fetch addr, cache hit data, imem bus (if), proc data, fill port, mshr_full.
module icache_prefetch_ctrl
    import icache_prefetch_pkg::*;
#(
    parameter int N_MSHR   = 4,
    parameter int PF_DEPTH = 2,
    parameter int TAG_W    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [XLEN-1:0]       proc2Ictrl_addr,
    input  logic [63:0]           Icache2Ictrl_data,
    input  logic                  Icache2Ictrl_valid,
    icache_prefetch_ctrl_if.master imem,
    output logic [63:0]           Ictrl2proc_data,
    output logic                  Ictrl2proc_valid,
    output logic [MEM_ADDR_W-1:0] current_addr,
    output logic                  Ictrl2Icache_mem_write_en,
    output logic [MEM_ADDR_W-1:0] Ictrl2Icache_wr_addr,
    output logic [63:0]           Ictrl2Icache_wr_data,
    output logic                  mshr_full
);
    localparam int         IW  = $clog2(N_MSHR);
    localparam logic [2:0] PFD = 3'(PF_DEPTH);

    logic [N_MSHR-1:0] valid_q;
    logic [12:0]       line_q [N_MSHR];
    logic [TAG_W-1:0]  tag_q  [N_MSHR];
    logic [2:0]        pf_off_q;
    logic [12:0]       last_line_q;

    logic [12:0]      demand_line, pf_line, issue_line, fill_line;
    logic [2:0]       eff_off, pf_next;
    logic             dem_in, pf_in, dem_cand, pf_room, pf_cand;
    logic             full, dem_issue, pf_issue, issue, accept;
    logic             fill_hit, alloc_ok;
    logic [IW-1:0]    fill_idx, alloc_idx;
    logic [TAG_W-1:0] eff_resp;
    logic             addr_unused;

    assign addr_unused = ^{proc2Ictrl_addr[XLEN-1:16],
                           proc2Ictrl_addr[2:0], alloc_ok};

    assign demand_line = proc2Ictrl_addr[15:3];
    assign current_addr = proc2Ictrl_addr[15:0];
    // A new demand line restarts the prefetch window this very cycle.
    assign eff_off = (demand_line != last_line_q) ? 3'd0 : pf_off_q;
    assign pf_line = demand_line + 13'(eff_off) + 13'd1;

    always_comb begin
        dem_in    = 1'b0;
        pf_in     = 1'b0;
        fill_hit  = 1'b0;
        fill_idx  = '0;
        fill_line = '0;
        alloc_ok  = 1'b0;
        alloc_idx = '0;
        for (int i = 0; i < N_MSHR; i++) begin
            if (valid_q[i] && line_q[i] == demand_line)
                dem_in = 1'b1;
            if (valid_q[i] && line_q[i] == pf_line)
                pf_in = 1'b1;
            if (!fill_hit && valid_q[i] &&
                imem.Imem2Ictrl_tag != '0 &&
                tag_q[i] == imem.Imem2Ictrl_tag) begin
                fill_hit  = 1'b1;
                fill_idx  = IW'(i);
                fill_line = line_q[i];
            end
            // Start-of-cycle valid bits: a slot freed by a fill is not reused now.
            if (!alloc_ok && !valid_q[i]) begin
                alloc_ok  = 1'b1;
                alloc_idx = IW'(i);
            end
        end
    end

    assign full       = &valid_q;
    assign dem_cand   = !Icache2Ictrl_valid && !dem_in;
    assign pf_room    = eff_off < PFD;
    assign pf_cand    = pf_room && !pf_in;
    assign dem_issue  = !full && dem_cand;
    assign pf_issue   = !full && !dem_cand && pf_cand;
    assign issue      = dem_issue || pf_issue;
    assign issue_line = dem_cand ? demand_line : pf_line;
    assign eff_resp   = imem.reject_I_req ? '0 : imem.Imem2Ictrl_response;
    assign accept     = issue && eff_resp != '0;

    // Lines already in flight advance the window without using the bus.
    always_comb begin
        pf_next = eff_off;
        if (pf_room && (pf_in || (pf_issue && eff_resp != '0)))
            pf_next = eff_off + 3'd1;
    end

    assign imem.Ictrl2Imem_command =
        (!reset && issue) ? BUS_LOAD : BUS_NONE;
    assign imem.Ictrl2Imem_addr = {16'b0, issue_line, 3'b0};

    assign Ictrl2Icache_mem_write_en = !reset && fill_hit;
    assign Ictrl2Icache_wr_addr      = {fill_line, 3'b0};
    assign Ictrl2Icache_wr_data      = imem.Imem2Ictrl_data;

    // Cache hit wins; otherwise forward a fill landing on the demand line.
    assign Ictrl2proc_valid = !reset && (Icache2Ictrl_valid ||
                              (fill_hit && fill_line == demand_line));
    assign Ictrl2proc_data  = Icache2Ictrl_valid ? Icache2Ictrl_data
                                                 : imem.Imem2Ictrl_data;
    assign mshr_full = !reset && full;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q     <= '0;
            pf_off_q    <= 3'd0;
            last_line_q <= 13'h1FFF;
        end else begin
            if (fill_hit)
                valid_q[fill_idx] <= 1'b0;
            if (accept) begin
                valid_q[alloc_idx] <= 1'b1;
                line_q[alloc_idx]  <= issue_line;
                tag_q[alloc_idx]   <= eff_resp;
            end
            pf_off_q    <= pf_next;
            last_line_q <= demand_line;
        end
    end
endmodule
